dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares one single-port, 4-byte-lane, little-endian data RAM between the instruction-fetch
//  port (IF, word reads) and the load/store port (DM, byte/half/word, signed/unsigned).
//  Sits between the pipeline fetch/MEM stages and the RAM. Handles arbitration with
//  anti-starvation, byte-enable and lane alignment, load extension and response routing.
// PARAMETERS
//  AW        10  RAM word-address width (ram_addr = addr[AW+1:2])
//  MAX_WAIT  4   cycles IF may be refused before it takes priority (>=1)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous reset, active-high
//  if_req     in   1   fetch request, held until if_gnt
//  if_addr    in   32  fetch byte address (bits [1:0] ignored)
//  if_gnt     out  1   request accepted this cycle (combinational)
//  if_rvalid  out  1   if_rdata valid (1 cycle after if_gnt)
//  if_rdata   out  32  fetched word
//  dm_req     in   1   load/store request, held until dm_gnt
//  dm_we      in   1   1=store, 0=load
//  dm_size    in   2   00 none, 01 byte, 10 half, 11 word
//  dm_sign    in   1   loads: 1=sign-extend, 0=zero-extend
//  dm_addr    in   32  byte address
//  dm_wdata   in   32  store data, right-justified
//  dm_gnt     out  1   request accepted this cycle (combinational)
//  dm_rvalid  out  1   load data / store ack valid (1 cycle after dm_gnt)
//  dm_rdata   out  32  extended load data (0 for stores)
//  ram_en     out  1   RAM access this cycle
//  ram_we     out  4   byte write enables, bit i = byte lane i
//  ram_addr   out  AW  RAM word address
//  ram_wdata  out  32  lane-aligned store data
//  ram_rdata  in   32  RAM read data, registered, valid 1 cycle after ram_en
//  dm_adel    out  1   [ADDR_EXC_EN] misaligned load, qualifies dm_rvalid
//  dm_ades    out  1   [ADDR_EXC_EN] misaligned store, qualifies dm_rvalid
// BEHAVIOUR
//  - One RAM access per cycle. Grant is combinational in the cycle the access drives the RAM.
//  - Priority: DM wins, unless starve_cnt==MAX_WAIT, then IF wins. The loser's gnt is 0.
//  - starve_cnt: increments while if_req&&!if_gnt (saturates at MAX_WAIT). Clears on if_gnt.
//  - Response tag registered at grant: owner, addr[1:0], size, sign, we. Next cycle the owner's
//    rvalid=1 for exactly one cycle. Back-to-back grants give back-to-back rvalid.
//  - Store lanes: byte we=4'b0001<<a[1:0], wdata={4{b}}. Half we=4'b0011<<{a[1],1'b0},
//    wdata={2{h}}. Word we=4'b1111. Loads and IF: ram_we=0.
//  - Load extract: ram_rdata>>(8*a[1:0]) for byte, >>(16*a[1]) for half, then extend per dm_sign.
//  - dm_size==00: granted. ram_en=0. rvalid next cycle with rdata=0.
//  - Idle cycle (no req): ram_en=0, ram_we=0. ram_addr/ram_wdata are don't-care.
//  - Reset: all outputs 0. starve_cnt=0. Response tag invalid. Reset mid-access drops the
//    pending rvalid. No response is issued after reset.
// CONFIGURATION
//  DMEM_ADDR_EXC_EN defined: half with a[0]!=0 or word with a[1:0]!=0 is granted.
//    ram_en=0 and ram_we=0 (no RAM effect). Next cycle dm_rvalid=1, dm_rdata=0, and dm_adel
//    (load) or dm_ades (store)=1 for that cycle.
//  Undefined: no dm_adel/dm_ades ports. Misaligned low bits are forced to 0 (half: a[0],
//    word: a[1:0]) and the access proceeds aligned.
// STRUCTURE
//  dmem_pkg: size encodings (SZ_NONE/BYTE/HALF/WORD), owner enum (OWN_IF/OWN_DM),
//    response-tag struct.
//  Sub-module dmem_lane_align (combinational): store we/wdata generation and
//    load extract/extend. Instantiated once for the store path and once for the load path.
//  Top level: arbiter, starve_cnt, response-tag register, output muxing.
// TESTING
//  1 IF-only: if_req, addr 0x40, RAM word 0x11223344 -> if_gnt same cycle, next cycle
//    if_rvalid=1, rdata=0x11223344.
//  2 sb 0xA5 @0x103 -> ram_we=1000, ram_wdata=0xA5A5A5A5. Then lb signed @0x103 ->
//    dm_rdata=0xFFFFFFA5. lbu -> 0x000000A5.
//  3 sh 0x8001 @0x102 -> ram_we=1100. lh @0x102 -> 0xFFFF8001. lhu -> 0x00008001.
//  4 Contention: dm_req and if_req held continuously -> DM granted 4 cycles, IF granted on
//    the 5th cycle, repeating. Each rvalid goes to the correct owner.
//  5 lw @0x101: with DMEM_ADDR_EXC_EN -> ram_en=0, dm_adel=1 with dm_rvalid, rdata=0.
//    Without it -> reads word @0x100.
//  6 Assert rst in the cycle after dm_gnt -> no dm_rvalid, all outputs 0, and on release
//    if_gnt is immediate.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_pkg
// Brief  : Shared types for the data-RAM arbiter. Access-size encodings,
//          response owner and the response tag that is captured at grant time.
// Rev    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Access size as carried on dm_size
    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } size_e;

    // Which requester receives the response of a granted access
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Captured at grant and used one cycle later to route and shape the response
    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] lo;     // effective byte offset inside the word
        size_e      size;
        logic       sign;
        logic       we;
        logic       err;    // misaligned access (only with address exceptions)
    } rsp_tag_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter_if
// Brief  : Bundles the fetch port, load/store port and RAM port of the data
//          RAM arbiter. The slave modport is the arbiter's view; the master
//          modport is the view of the pipeline + RAM around it.
//          DMEM_ADDR_EXC_EN adds dm_adel / dm_ades.
// Rev    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 10
);
    // Fetch port
    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [31:0]   if_rdata;
    // Load/store port
    logic          dm_req;
    logic          dm_we;
    logic [1:0]    dm_size;
    logic          dm_sign;
    logic [31:0]   dm_addr;
    logic [31:0]   dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [31:0]   dm_rdata;
    // RAM port
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

`ifdef DMEM_ADDR_EXC_EN
    logic          dm_adel;
    logic          dm_ades;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_sign, dm_addr, dm_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, dm_adel, dm_ades
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_sign, dm_addr, dm_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, dm_adel, dm_ades
    );
`else
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_sign, dm_addr, dm_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_sign, dm_addr, dm_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
`endif

endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module : dmem_lane_align
// Brief  : Combinational little-endian lane logic for a 4-byte-lane RAM.
//          Store side: byte enables and replicated write data.
//          Load side : extract the addressed byte/half and sign/zero extend.
// Ports  : i_size    access size
//          i_addr_lo byte offset inside the word
//          i_sign    1 = sign-extend loads
//          i_st_data right-justified store data
//          i_ld_data raw RAM word
//          o_st_we   byte write enables (bit i = lane i)
//          o_st_data lane-aligned store data
//          o_ld_data extended load data (0 for SZ_NONE)
// Rev    : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_sign,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_data,
    output logic [3:0]  o_st_we,
    output logic [31:0] o_st_data,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Variable part-selects pick the addressed lane(s) directly
    assign w_byte = i_ld_data[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_ld_data[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_st_we   = 4'b0000;
        o_st_data = 32'h0;
        o_ld_data = 32'h0;
        case (i_size)
            SZ_BYTE: begin
                o_st_we   = 4'b0001 << i_addr_lo;
                o_st_data = {4{i_st_data[7:0]}};
                o_ld_data = {{24{i_sign & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_st_we   = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_st_data = {2{i_st_data[15:0]}};
                o_ld_data = {{16{i_sign & w_half[15]}}, w_half};
            end
            SZ_WORD: begin
                o_st_we   = 4'b1111;
                o_st_data = i_st_data;
                o_ld_data = i_ld_data;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Brief  : Shares one single-port, 4-lane little-endian data RAM between the
//          instruction-fetch port and the load/store port. DM has priority
//          unless IF has been refused MAX_WAIT times in a row. Grants are
//          combinational; responses come exactly one cycle after grant.
// Ports  : clk, rst (synchronous, active-high)
//          bus : dmem_arbiter_if.slave
//                fetch  : if_req/if_addr -> if_gnt, if_rvalid, if_rdata
//                ld/st  : dm_req/we/size/sign/addr/wdata -> dm_gnt,
//                         dm_rvalid, dm_rdata (+ dm_adel/dm_ades)
//                RAM    : ram_en, ram_we, ram_addr, ram_wdata <- ram_rdata
// Config : DMEM_ADDR_EXC_EN - misaligned half/word accesses are not
//          performed and are reported on dm_adel/dm_ades. Undefined: the
//          misaligned low address bits are dropped and the access proceeds.
// Rev    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW       = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int                  c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0]  c_MAX_WAIT = c_CNT_W'(MAX_WAIT);

    logic [c_CNT_W-1:0] r_starve_cnt;
    rsp_tag_t           r_tag;

    logic        w_if_win;
    logic        w_if_gnt;
    logic        w_dm_gnt;
    logic        w_dm_ram;
    size_e       w_dm_size;
    logic [1:0]  w_dm_lo;
    logic        w_dm_err;
    logic [3:0]  w_st_we;
    logic [31:0] w_st_data;
    logic [31:0] w_st_unused_ld;
    logic [3:0]  w_ld_unused_we;
    logic [31:0] w_ld_unused_st;
    logic [31:0] w_ld_data;
    logic        w_rv;
    logic        w_if_rvalid;
    logic        w_dm_rvalid;

    // ------------------------------------------------------------------
    // Arbitration: DM wins unless IF has been starved long enough.
    // Reset masks both grants so no access or tag is taken during reset.
    // ------------------------------------------------------------------
    assign w_if_win = bus.if_req && (!bus.dm_req || (r_starve_cnt == c_MAX_WAIT));
    assign w_if_gnt = !rst && w_if_win;
    assign w_dm_gnt = !rst && bus.dm_req && !w_if_win;

    assign w_dm_size = size_e'(bus.dm_size);

    // Effective offset and misalignment classification
    always_comb begin
        w_dm_lo  = bus.dm_addr[1:0];
        w_dm_err = 1'b0;
        if (w_dm_size == SZ_HALF) begin
`ifdef DMEM_ADDR_EXC_EN
            w_dm_err = bus.dm_addr[0];
`else
            w_dm_lo[0] = 1'b0;
`endif
        end else if (w_dm_size == SZ_WORD) begin
`ifdef DMEM_ADDR_EXC_EN
            w_dm_err = (bus.dm_addr[1:0] != 2'b00);
`else
            w_dm_lo = 2'b00;
`endif
        end
    end

    // A DM grant only touches the RAM for a real, correctly aligned access
    assign w_dm_ram = w_dm_gnt && (w_dm_size != SZ_NONE) && !w_dm_err;

    dmem_lane_align u_store_align (
        .i_size    (w_dm_size),
        .i_addr_lo (w_dm_lo),
        .i_sign    (bus.dm_sign),
        .i_st_data (bus.dm_wdata),
        .i_ld_data (32'h0),
        .o_st_we   (w_st_we),
        .o_st_data (w_st_data),
        .o_ld_data (w_st_unused_ld)
    );

    // ------------------------------------------------------------------
    // RAM drive
    // ------------------------------------------------------------------
    assign bus.ram_en    = w_if_gnt || w_dm_ram;
    assign bus.ram_we    = (w_dm_ram && bus.dm_we) ? w_st_we : 4'b0000;
    assign bus.ram_wdata = (w_dm_ram && bus.dm_we) ? w_st_data : 32'h0;
    assign bus.ram_addr  = w_if_gnt ? bus.if_addr[AW+1:2] :
                           (w_dm_ram ? bus.dm_addr[AW+1:2] : '0);

    assign bus.if_gnt = w_if_gnt;
    assign bus.dm_gnt = w_dm_gnt;

    // ------------------------------------------------------------------
    // Starvation counter and response tag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_tag        <= '0;
        end else begin
            if (w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (bus.if_req && (r_starve_cnt != c_MAX_WAIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            r_tag.valid <= w_if_gnt || w_dm_gnt;
            r_tag.owner <= w_if_gnt ? OWN_IF : OWN_DM;
            r_tag.lo    <= w_dm_lo;
            r_tag.size  <= w_dm_size;
            r_tag.sign  <= bus.dm_sign;
            r_tag.we    <= bus.dm_we;
            r_tag.err   <= w_dm_err;
        end
    end

    // ------------------------------------------------------------------
    // Response routing. Gating with rst drops a response that is due in
    // the reset cycle itself, so every output reads 0 while rst is high.
    // ------------------------------------------------------------------
    dmem_lane_align u_load_align (
        .i_size    (r_tag.size),
        .i_addr_lo (r_tag.lo),
        .i_sign    (r_tag.sign),
        .i_st_data (32'h0),
        .i_ld_data (bus.ram_rdata),
        .o_st_we   (w_ld_unused_we),
        .o_st_data (w_ld_unused_st),
        .o_ld_data (w_ld_data)
    );

    assign w_rv        = r_tag.valid && !rst;
    assign w_if_rvalid = w_rv && (r_tag.owner == OWN_IF);
    assign w_dm_rvalid = w_rv && (r_tag.owner == OWN_DM);

    assign bus.if_rvalid = w_if_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.ram_rdata : 32'h0;
    assign bus.dm_rvalid = w_dm_rvalid;
    assign bus.dm_rdata  = (w_dm_rvalid && !r_tag.we && !r_tag.err) ? w_ld_data : 32'h0;

`ifdef DMEM_ADDR_EXC_EN
    assign bus.dm_adel = w_dm_rvalid && r_tag.err && !r_tag.we;
    assign bus.dm_ades = w_dm_rvalid && r_tag.err && r_tag.we;
`endif

    // Address bits outside the RAM word range and unused lane outputs
    logic w_unused;
    assign w_unused = ^{bus.if_addr[31:AW+2], bus.if_addr[1:0], bus.dm_addr[31:AW+2],
                        w_st_unused_ld, w_ld_unused_we, w_ld_unused_st};

endmodule
`default_nettype wire
